// File: rtl/intrp_proc_agent.sv
`default_nettype none
// ============================================================================
// intrp_proc_agent : programs the interrupt controller's priority registers,
//                    then services interrupts one at a time.
// Revision 1.0
// ============================================================================
module intrp_proc_agent #(
  parameter int NUM_PHER   = 16,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int IDW        = 4,
  parameter int SVC_CYCLES = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_start_i,
  input  logic [NUM_PHER*WIDTH-1:0] prio_init_i,
  output logic                      sel_o,
  output logic                      enable_o,
  output logic                      write_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [WIDTH-1:0]          wdata_o,
  input  logic                      ready_i,
  input  logic                      error_i,
  output logic                      init_done_o,
  output logic                      bus_err_o,
  input  logic                      intrp_valid_i,
  input  logic [NUM_PHER-1:0]       pher_with_intrp_i,
  output logic                      intrp_serviced_o,
  output logic [NUM_PHER-1:0]       int_clear_o,
  output logic                      svc_busy_o,
  output logic [IDW-1:0]            svc_id_o,
  output logic [15:0]               svc_count_o
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_INIT_IDLE = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_RUN_IDLE  = 3'd3,
    S_CAPTURE   = 3'd4,
    S_SERVICE   = 3'd5,
    S_ACK       = 3'd6,
    S_COOLDOWN  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic [IDW-1:0]   svc_id_q, svc_id_d;
  logic [15:0]      svc_count_q, svc_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
      svc_id_q    <= '0;
      svc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
      svc_id_q    <= svc_id_d;
      svc_count_q <= svc_count_d;
    end
  end

  // cnt_q is shared: access timeout, service length and cooldown never overlap
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    svc_id_d    = svc_id_q;
    svc_count_d = svc_count_q;
    case (state_q)
      S_INIT_IDLE: begin
        if (init_start_i) begin
          state_d = S_SETUP;
          idx_d   = '0;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (ready_i || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          if (ready_i) begin
            bus_err_d = bus_err_q | error_i;
          end else begin
            bus_err_d = 1'b1;
          end
          if (idx_q == IDW'(NUM_PHER - 1)) begin
            state_d = S_RUN_IDLE;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN_IDLE: begin
        if (intrp_valid_i) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Out-of-range index is flagged but the low bits are still serviced
        svc_id_d = pher_with_intrp_i[IDW-1:0];
        if (|pher_with_intrp_i[NUM_PHER-1:IDW]) begin
          bus_err_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (cnt_q == CNT_W'(SVC_CYCLES - 1)) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        if (svc_count_q != 16'hFFFF) begin
          svc_count_d = svc_count_q + 1'b1;
        end
        cnt_d   = '0;
        state_d = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RUN_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_INIT_IDLE;
      end
    endcase
  end

  always_comb begin
    sel_o    = 1'b0;
    enable_o = 1'b0;
    write_o  = 1'b0;
    addr_o   = '0;
    wdata_o  = '0;
    if ((state_q == S_SETUP) || (state_q == S_ACCESS)) begin
      sel_o    = 1'b1;
      enable_o = (state_q == S_ACCESS);
      write_o  = 1'b1;
      addr_o   = ADDR_WIDTH'(idx_q);
      wdata_o  = prio_init_i[int'(idx_q)*WIDTH +: WIDTH];
    end
  end

  assign init_done_o      = (state_q == S_RUN_IDLE) || (state_q == S_CAPTURE) ||
                            (state_q == S_SERVICE)  || (state_q == S_ACK)     ||
                            (state_q == S_COOLDOWN);
  assign bus_err_o        = bus_err_q;
  assign intrp_serviced_o = (state_q == S_ACK);
  assign svc_busy_o       = (state_q == S_SERVICE);
  assign int_clear_o      = (state_q == S_SERVICE) ? (NUM_PHER'(1) << svc_id_q) : '0;
  assign svc_id_o         = svc_id_q;
  assign svc_count_o      = svc_count_q;

endmodule
`default_nettype wire

// File: tb/tb_intrp_proc_agent.sv
`default_nettype none
// ============================================================================
// tb_intrp_proc_agent : randomized bench with a schedule-level reference model
// Revision 1.0
// ============================================================================
module tb_intrp_proc_agent;

  localparam int NUM_PHER   = 16;
  localparam int WIDTH      = 16;
  localparam int ADDR_WIDTH = 16;
  localparam int IDW        = 4;
  localparam int SVC_CYCLES = 8;
  localparam int TIMEOUT    = 15;
  localparam int PERIOD     = SVC_CYCLES + 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      init_start_i = 1'b0;
  logic [NUM_PHER*WIDTH-1:0] prio_init_i = '0;
  logic                      ready_i = 1'b0;
  logic                      error_i = 1'b0;
  logic                      intrp_valid_i = 1'b0;
  logic [NUM_PHER-1:0]       pher_with_intrp_i = '0;
  logic                      sel_o, enable_o, write_o;
  logic [ADDR_WIDTH-1:0]     addr_o;
  logic [WIDTH-1:0]          wdata_o;
  logic                      init_done_o, bus_err_o, intrp_serviced_o, svc_busy_o;
  logic [NUM_PHER-1:0]       int_clear_o;
  logic [IDW-1:0]            svc_id_o;
  logic [15:0]               svc_count_o;
  logic [74:0]               all_out;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic        model_err = 1'b0;
  int          model_count = 0;
  logic [15:0] ids [0:3];

  assign all_out = {sel_o, enable_o, write_o, addr_o, wdata_o, init_done_o, bus_err_o,
                    intrp_serviced_o, int_clear_o, svc_busy_o, svc_id_o, svc_count_o};

  always #5 clk = ~clk;

  intrp_proc_agent #(
    .NUM_PHER(NUM_PHER), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .IDW(IDW), .SVC_CYCLES(SVC_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .init_start_i(init_start_i), .prio_init_i(prio_init_i),
    .sel_o(sel_o), .enable_o(enable_o), .write_o(write_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .ready_i(ready_i), .error_i(error_i), .init_done_o(init_done_o),
    .bus_err_o(bus_err_o), .intrp_valid_i(intrp_valid_i),
    .pher_with_intrp_i(pher_with_intrp_i), .intrp_serviced_o(intrp_serviced_o),
    .int_clear_o(int_clear_o), .svc_busy_o(svc_busy_o), .svc_id_o(svc_id_o),
    .svc_count_o(svc_count_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_start_i = 1'b0; intrp_valid_i = 1'b0; ready_i = 1'b0; error_i = 1'b0;
    step(); step();
    n_cmp++;
    if (all_out !== '0) begin
      n_mis++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst = 1'b0; model_err = 1'b0; model_count = 0;
    step();
    n_cmp++;
    if (all_out !== '0) begin
      n_mis++; $display("FAIL idle_after_reset: got %h expected 0", all_out);
    end
  endtask

  // Programs all registers; stall_idx never gets ready, err_idx answers with error
  task automatic test_init(input int stall_idx, input int err_idx);
    int n_acc = 0;
    int acc_cyc = 0;
    int delay = 0;
    int cyc = 0;
    int exp_len;
    bit done = 1'b0;
    for (int i = 0; i < NUM_PHER; i++) prio_init_i[i*WIDTH +: WIDTH] = 16'($urandom);
    init_start_i = 1'b1;
    step();
    init_start_i = 1'b0;
    while (!done && cyc < 2000) begin
      ready_i = 1'b0;
      error_i = 1'b0;
      if (((sel_o && !enable_o) || init_done_o) && n_acc > 0) begin
        exp_len = (n_acc - 1 == stall_idx) ? TIMEOUT : delay + 1;
        n_cmp++;
        if (acc_cyc != exp_len) begin
          n_mis++; $display("FAIL access_len[%0d]: got %0d expected %0d", n_acc - 1, acc_cyc, exp_len);
        end
        if (n_acc - 1 == stall_idx || n_acc - 1 == err_idx) model_err = 1'b1;
      end
      if (sel_o && !enable_o) begin
        n_cmp++;
        if ({write_o, addr_o, wdata_o} !== {1'b1, 16'(n_acc), prio_init_i[n_acc*WIDTH +: WIDTH]}) begin
          n_mis++; $display("FAIL setup[%0d]: got w=%b a=%h d=%h expected a=%h d=%h", n_acc,
                            write_o, addr_o, wdata_o, 16'(n_acc), prio_init_i[n_acc*WIDTH +: WIDTH]);
        end
        n_cmp++;
        if (bus_err_o !== model_err) begin
          n_mis++; $display("FAIL bus_err_init[%0d]: got %b expected %b", n_acc, bus_err_o, model_err);
        end
        delay = (n_acc == stall_idx) ? 1000 : int'($urandom_range(0, 3));
        acc_cyc = 0;
        n_acc++;
      end else if (sel_o && enable_o) begin
        if (acc_cyc == delay) begin
          ready_i = 1'b1;
          error_i = (n_acc - 1 == err_idx);
        end else begin
          error_i = 1'($urandom_range(0, 1));
        end
        acc_cyc++;
      end else if (init_done_o) begin
        n_cmp++;
        if (n_acc != NUM_PHER) begin
          n_mis++; $display("FAIL access_count: got %0d expected %0d", n_acc, NUM_PHER);
        end
        n_cmp++;
        if (bus_err_o !== model_err) begin
          n_mis++; $display("FAIL bus_err_done: got %b expected %b", bus_err_o, model_err);
        end
        done = 1'b1;
      end
      if (!done) begin
        n_cmp++;
        if ({svc_busy_o, intrp_serviced_o, int_clear_o} !== '0) begin
          n_mis++; $display("FAIL service_during_init: got %b%b %h expected 0",
                            svc_busy_o, intrp_serviced_o, int_clear_o);
        end
      end
      intrp_valid_i = done ? 1'b0 : 1'($urandom_range(0, 1));
      pher_with_intrp_i = 16'($urandom);
      if (!done) step();
      cyc++;
    end
    ready_i = 1'b0;
    error_i = 1'b0;
    if (!done) begin
      n_cmp++; n_mis++;
      $display("FAIL init_timeout: got init_done=%b expected 1", init_done_o);
    end
  endtask

  // Services ids[0..n-1]; intrp_valid stays high until the last capture
  task automatic test_service(input int n);
    int kdrop;
    int total;
    logic [NUM_PHER-1:0] exp_clr;
    logic exp_busy, exp_serv;
    total = n * PERIOD + 2;
    kdrop = (n == 1) ? int'($urandom_range(1, SVC_CYCLES)) : 1 + (n - 1) * PERIOD;
    intrp_valid_i = 1'b1;
    pher_with_intrp_i = ids[0];
    step();
    for (int k = 1; k <= total; k++) begin
      int j = (k - 1) / PERIOD;
      int p = (k - 1) % PERIOD;
      exp_busy = 1'b0; exp_serv = 1'b0; exp_clr = '0;
      if (j < n) begin
        if (p >= 1 && p <= SVC_CYCLES) begin
          exp_busy = 1'b1;
          exp_clr  = 16'(1) << ids[j][IDW-1:0];
        end
        if (p == SVC_CYCLES + 1) exp_serv = 1'b1;
      end
      n_cmp++;
      if ({intrp_serviced_o, svc_busy_o, int_clear_o} !== {exp_serv, exp_busy, exp_clr}) begin
        n_mis++; $display("FAIL service_k%0d: got serv=%b busy=%b clr=%h expected serv=%b busy=%b clr=%h",
                          k, intrp_serviced_o, svc_busy_o, int_clear_o, exp_serv, exp_busy, exp_clr);
      end
      if (exp_busy) begin
        n_cmp++;
        if (svc_id_o !== ids[j][IDW-1:0]) begin
          n_mis++; $display("FAIL svc_id_k%0d: got %h expected %h", k, svc_id_o, ids[j][IDW-1:0]);
        end
      end
      if (exp_serv) begin
        model_count = (model_count == 65535) ? 65535 : model_count + 1;
        if (|ids[j][15:IDW]) model_err = 1'b1;
      end
      intrp_valid_i = (k < kdrop);
      pher_with_intrp_i = ((k % PERIOD == 1) && (k / PERIOD < n)) ? ids[k / PERIOD] : 16'($urandom);
      step();
    end
    intrp_valid_i = 1'b0;
    n_cmp++;
    if (svc_count_o !== 16'(model_count)) begin
      n_mis++; $display("FAIL svc_count: got %0d expected %0d", svc_count_o, model_count);
    end
    n_cmp++;
    if (bus_err_o !== model_err) begin
      n_mis++; $display("FAIL bus_err_svc: got %b expected %b", bus_err_o, model_err);
    end
  endtask

  task automatic test_single();
    ids[0] = 16'd5;
    test_service(1);
  endtask

  task automatic test_back_to_back();
    ids[0] = 16'd2;
    ids[1] = 16'd9;
    test_service(2);
  endtask

  task automatic test_random_services();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) ids[i] = 16'($urandom_range(0, NUM_PHER - 1));
      test_service(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_bad_index();
    ids[0] = 16'h0013;
    test_service(1);
    n_cmp++;
    if ({bus_err_o, svc_id_o} !== {1'b1, 4'd3}) begin
      n_mis++; $display("FAIL bad_index: got err=%b id=%h expected err=1 id=3", bus_err_o, svc_id_o);
    end
  endtask

  task automatic test_reset_mid_service();
    int err_idx;
    intrp_valid_i = 1'b1;
    pher_with_intrp_i = 16'($urandom_range(0, NUM_PHER - 1));
    step(); step(); step(); step();
    n_cmp++;
    if (svc_busy_o !== 1'b1) begin
      n_mis++; $display("FAIL pre_reset_busy: got %b expected 1", svc_busy_o);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (all_out !== '0) begin
      n_mis++; $display("FAIL mid_service_reset: got %h expected 0", all_out);
    end
    rst = 1'b0; model_err = 1'b0; model_count = 0;
    for (int c = 0; c < 20; c++) begin
      intrp_valid_i = 1'b1;
      pher_with_intrp_i = 16'($urandom);
      step();
      n_cmp++;
      if ({init_done_o, svc_busy_o, intrp_serviced_o, int_clear_o} !== '0) begin
        n_mis++; $display("FAIL valid_before_reinit: got %b%b%b %h expected 0",
                          init_done_o, svc_busy_o, intrp_serviced_o, int_clear_o);
      end
    end
    intrp_valid_i = 1'b0;
    err_idx = int'($urandom_range(4, NUM_PHER - 1));
    test_init(3, err_idx);
    ids[0] = 16'($urandom_range(0, NUM_PHER - 1));
    test_service(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_init(-1, -1);
    test_single();
    test_back_to_back();
    test_random_services();
    test_bad_index();
    test_reset_mid_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
